// File: rtl/mem_responder.sv
// Line-wide backing-store responder: captures one request, answers after LATENCY edges.
// Optional build macro MEM_STATS_EN adds saturating read/write counters.
module mem_responder #(
   parameter int LINE_W  = 64,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              mem_req_valid,
   input  logic              mem_req_rw,
   input  logic [ADDR_W-1:0] mem_req_addr,
   input  logic [LINE_W-1:0] mem_req_data,
   output logic              mem_res_ready,
   output logic [LINE_W-1:0] mem_res_data,
   output logic              busy
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam int         IDX_W    = $clog2(DEPTH);
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   logic [7:0]          r_cnt;
   logic                r_rw;
   logic [IDX_W-1:0]    r_idx;
   logic [LINE_W-1:0]   r_wdata;
   logic                r_ready;
   logic [LINE_W-1:0]   r_data;
   logic                r_busy;

   logic [LINE_W-1:0]   r_mem [DEPTH];
   logic [LINE_W-1:0]   r_mem_q;

   logic [IDX_W-1:0]    w_req_idx;
   logic [IDX_W-1:0]    w_rd_idx;
   logic                w_commit;
   logic                w_unused_addr;

   assign w_req_idx     = mem_req_addr[3 +: IDX_W];
   assign w_unused_addr = ^{mem_req_addr[2:0], mem_req_addr[ADDR_W-1:3+IDX_W]};
   // In IDLE the read port follows the incoming address so the line is ready even for LATENCY==1.
   assign w_rd_idx      = (r_state == S_IDLE) ? w_req_idx : r_idx;
   assign w_commit      = (r_state == S_RESP) && r_rw;

   always_ff @(posedge clk) begin
      if (w_commit) begin
         r_mem[r_idx] <= r_wdata;
      end
      r_mem_q <= r_mem[w_rd_idx];
   end

   // A load of LATENCY-1 followed by countdown-to-zero in WAIT puts RESP exactly LATENCY edges after capture.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_rw    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_ready <= 1'b0;
         r_data  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (mem_req_valid) begin
                  r_rw    <= mem_req_rw;
                  r_idx   <= w_req_idx;
                  r_wdata <= mem_req_data;
                  r_cnt   <= CNT_LOAD;
                  r_busy  <= 1'b1;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 8'd0) begin
                  r_ready <= 1'b1;
                  r_data  <= r_rw ? r_wdata : r_mem_q;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_RESP: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_res_ready = r_ready;
   assign mem_res_data  = r_data;
   assign busy          = r_busy;

`ifdef MEM_STATS_EN
   logic [15:0] r_rd_count;
   logic [15:0] r_wr_count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_rd_count <= 16'd0;
         r_wr_count <= 16'd0;
      end else if (r_state == S_RESP) begin
         if (r_rw && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
         if (!r_rw && (r_rd_count != 16'hFFFF)) begin
            r_rd_count <= r_rd_count + 16'd1;
         end
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder; stats checks compile in when MEM_STATS_EN is defined.
module tb_mem_responder;
   localparam int LAT   = 4;
   localparam int DEPTH = 256;

   logic        clk;
   logic        n_rst;
   logic        mem_req_valid;
   logic        mem_req_rw;
   logic [31:0] mem_req_addr;
   logic [63:0] mem_req_data;
   logic        mem_res_ready;
   logic [63:0] mem_res_data;
   logic        busy;
`ifdef MEM_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
`endif

   mem_responder #(.LINE_W(64), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .mem_req_valid (mem_req_valid),
      .mem_req_rw    (mem_req_rw),
      .mem_req_addr  (mem_req_addr),
      .mem_req_data  (mem_req_data),
      .mem_res_ready (mem_res_ready),
      .mem_res_data  (mem_res_data),
      .busy          (busy)
`ifdef MEM_STATS_EN
      ,
      .rd_count      (rd_count),
      .wr_count      (wr_count)
`endif
   );

   typedef struct {
      logic [63:0] data;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   total  = 0;
   int   bad    = 0;
   int   cyc    = 0;
   int   rd_exp = 0;
   int   wr_exp = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every ready pulse must match the head of the scoreboard; data must hold otherwise.
   initial begin
      logic [63:0] hold;
      exp_t        e;
      hold = 64'd0;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            hold = 64'd0;
         end else if (mem_res_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_ready cyc=%0d data=%h required no pulse", cyc, mem_res_data);
            end else begin
               e = exp_q.pop_front();
               if (mem_res_data !== e.data) begin
                  bad++;
                  $display("FAIL res_data got=%h exp=%h", mem_res_data, e.data);
               end
               total++;
               if (cyc != e.cyc) begin
                  bad++;
                  $display("FAIL ready_latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
               end
               $display("resp cyc=%0d data=%h", cyc, mem_res_data);
               hold = e.data;
            end
         end else begin
            total++;
            if (mem_res_data !== hold) begin
               bad++;
               $display("FAIL data_hold got=%h exp=%h", mem_res_data, hold);
            end
         end
      end
   end

   task automatic wait_ready(input bit scramble, input bit keep);
      int nb;
      bit seen;
      nb   = 0;
      seen = 1'b0;
      for (int i = 0; i < LAT + 6; i++) begin
         @(negedge clk);
         if (busy) nb++;
         if (scramble && i == 0) begin
            mem_req_addr = 32'h10;
            mem_req_data = 64'hFFFF_0000_FFFF_0000;
         end
         if (mem_res_ready) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL ready_timeout got=none exp=pulse within %0d cycles", LAT + 6);
      end
      total++;
      if (nb != LAT + 1) begin
         bad++;
         $display("FAIL busy_cycles got=%0d exp=%0d", nb, LAT + 1);
      end
      if (!keep) mem_req_valid = 1'b0;
   endtask

   task automatic issue(input bit rw, input logic [31:0] a, input logic [63:0] d, input logic [63:0] e);
      @(negedge clk);
      mem_req_valid = 1'b1;
      mem_req_rw    = rw;
      mem_req_addr  = a;
      mem_req_data  = d;
      exp_q.push_back('{data: e, cyc: cyc + 1 + LAT});
      if (rw) wr_exp++;
      else    rd_exp++;
      $display("req rw=%0d addr=%h data=%h exp=%h", rw, a, d, e);
   endtask

   task automatic req(input bit rw, input logic [31:0] a, input logic [63:0] d, input logic [63:0] e);
      issue(rw, a, d, e);
      wait_ready(1'b0, 1'b0);
   endtask

   initial begin
      n_rst         = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_rw    = 1'b0;
      mem_req_addr  = 32'd0;
      mem_req_data  = 64'd0;

      // Reset held for 5 cycles: all outputs quiet.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (mem_res_ready !== 1'b0 || mem_res_data !== 64'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got ready=%b data=%h busy=%b exp 0/0/0", mem_res_ready, mem_res_data, busy);
         end
      end
      n_rst = 1'b1;

      req(1'b1, 32'h10, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D);
      req(1'b1, 32'h18, 64'h1818_1818_0000_0018, 64'h1818_1818_0000_0018);
      req(1'b0, 32'h10, 64'd0, 64'hDEADBEEF_CAFEF00D);
      req(1'b0, 32'h10 + DEPTH * 8, 64'd0, 64'hDEADBEEF_CAFEF00D);

      // Inputs scrambled during WAIT, then valid held one cycle past ready -> second request.
      issue(1'b0, 32'h18, 64'd0, 64'h1818_1818_0000_0018);
      wait_ready(1'b1, 1'b1);
      mem_req_addr = 32'h10;
      exp_q.push_back('{data: 64'hDEADBEEF_CAFEF00D, cyc: cyc + 2 + LAT});
      rd_exp++;
      $display("req rw=0 addr=%h (held valid) exp=%h", mem_req_addr, 64'hDEADBEEF_CAFEF00D);
      wait_ready(1'b0, 1'b0);

      req(1'b1, 32'h28, 64'h0000_2828_AAAA_5555, 64'h0000_2828_AAAA_5555);
      req(1'b0, 32'h28, 64'd0, 64'h0000_2828_AAAA_5555);

      // Write aborted by reset during WAIT.
      req(1'b1, 32'h20, 64'h1, 64'h1);
      @(negedge clk);
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b1;
      mem_req_addr  = 32'h20;
      mem_req_data  = 64'h2;
      $display("req rw=1 addr=%h data=%h (aborted by reset)", mem_req_addr, mem_req_data);
      repeat (2) @(negedge clk);
      n_rst         = 1'b0;
      mem_req_valid = 1'b0;
      rd_exp        = 0;
      wr_exp        = 0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      repeat (LAT + 4) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_after_abort got=%b exp=0", busy);
      end
      req(1'b0, 32'h20, 64'd0, 64'h1);
      req(1'b1, 32'h30, 64'h3030, 64'h3030);
      req(1'b0, 32'h30, 64'd0, 64'h3030);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end

`ifdef MEM_STATS_EN
      repeat (2) @(negedge clk);
      total++;
      if (rd_count !== 16'(rd_exp) || wr_count !== 16'(wr_exp)) begin
         bad++;
         $display("FAIL stats got rd=%0d wr=%0d exp rd=%0d wr=%0d", rd_count, wr_count, rd_exp, wr_exp);
      end
      n_rst = 1'b0;
      @(negedge clk);
      total++;
      if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
         bad++;
         $display("FAIL stats_reset got rd=%0d wr=%0d exp 0/0", rd_count, wr_count);
      end
      n_rst = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
